// File: rtl/arbitro_decodificador_if.sv
// Request/grant bundle between requesters and the decoder arbiter.
// master: arbiter side (drives sel/dec_en/busy/hold_cnt); slave: requester side (drives req).
interface arbitro_decodificador_if #(
  parameter int SEL_W = 3
);
  localparam int N = 1 << SEL_W;

  logic [N-1:0]     req;
  logic [SEL_W-1:0] sel;
  logic             dec_en;
  logic             busy;
  logic [7:0]       hold_cnt;

  modport master (
    input  req,
    output sel,
    output dec_en,
    output busy,
    output hold_cnt
  );

  modport slave (
    output req,
    input  sel,
    input  dec_en,
    input  busy,
    input  hold_cnt
  );
endinterface

// File: rtl/arbitro_decodificador.sv
// Round-robin arbiter driving a shared 3-to-8 decoder (sel/dec_en), MAX_HOLD-bounded grants,
// one dead cycle between grants. Ports: clk, rst_n (async low), bus (req in; sel/dec_en/busy/hold_cnt out).
// Define ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module arbitro_decodificador #(
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic clk,
  input  logic rst_n,
  arbitro_decodificador_if.master bus
);
  localparam int N = 1 << SEL_W;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] sel_n;
  logic [7:0]       hold_n;
  logic             dec_en_n;
  logic             busy_n;
  logic             any_req;
  logic             hold_done;
  logic             drop;

`ifndef ARB_FIXED_PRIORITY_EN
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_n;
`endif

  assign any_req   = |bus.req;
  assign hold_done = (bus.hold_cnt == HOLD_LAST);
  assign drop      = ~bus.req[bus.sel];

  // Scan from the far end down so the last hit is the nearest one.
  always_comb begin
    winner = '0;
`ifdef ARB_FIXED_PRIORITY_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) winner = SEL_W'(i);
    end
`else
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.req[ptr + SEL_W'(k)]) winner = ptr + SEL_W'(k);
    end
`endif
  end

  always_comb begin
    state_n = state;
    sel_n   = bus.sel;
    hold_n  = bus.hold_cnt;
`ifndef ARB_FIXED_PRIORITY_EN
    ptr_n   = ptr;
`endif
    case (state)
      IDLE: begin
        hold_n = 8'd0;
        if (any_req) begin
          state_n = GRANT;
          sel_n   = winner;
        end
      end
      GRANT: begin
        if (drop || hold_done) begin
          state_n = GAP;
          hold_n  = 8'd0;
`ifndef ARB_FIXED_PRIORITY_EN
          ptr_n   = bus.sel + 1'b1;
`endif
        end else begin
          hold_n = bus.hold_cnt + 8'd1;
        end
      end
      GAP: begin
        hold_n = 8'd0;
        if (any_req) begin
          state_n = GRANT;
          sel_n   = winner;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        hold_n  = 8'd0;
      end
    endcase
    dec_en_n = (state_n == GRANT);
    busy_n   = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.sel      <= '0;
      bus.dec_en   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.hold_cnt <= 8'd0;
    end else begin
      state        <= state_n;
      bus.sel      <= sel_n;
      bus.dec_en   <= dec_en_n;
      bus.busy     <= busy_n;
      bus.hold_cnt <= hold_n;
    end
  end

`ifndef ARB_FIXED_PRIORITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_n;
    end
  end
`endif
endmodule

// File: tb/tb_arbitro_decodificador.sv
// Self-checking bench for arbitro_decodificador (SEL_W=3, MAX_HOLD=4).
// Honours ARB_FIXED_PRIORITY_EN the same way the design does.
module tb_arbitro_decodificador;
  localparam int N    = 8;
  localparam int MAXH = 4;
  localparam int P_IDLE  = 0;
  localparam int P_GRANT = 1;
  localparam int P_GAP   = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  int m_phase;
  int m_sel;
  int m_cnt;
  int m_ptr;
  int grants[$];

  arbitro_decodificador_if #(.SEL_W(3)) bus ();

  arbitro_decodificador #(
    .SEL_W(3),
    .MAX_HOLD(MAXH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
`ifdef ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
`endif
    return -1;
  endfunction

  // Reference: spec-level phases, winner found by modular search.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= P_IDLE;
      m_sel   <= 0;
      m_cnt   <= 0;
      m_ptr   <= 0;
    end else if (m_phase == P_GRANT) begin
      if (!bus.req[m_sel] || m_cnt == MAXH - 1) begin
        m_phase <= P_GAP;
        m_cnt   <= 0;
        m_ptr   <= (m_sel + 1) % N;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (pick(bus.req, m_ptr) >= 0) begin
      m_phase <= P_GRANT;
      m_sel   <= pick(bus.req, m_ptr);
      m_cnt   <= 0;
      grants.push_back(pick(bus.req, m_ptr));
    end else begin
      m_phase <= P_IDLE;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("sel", int'(bus.sel), m_sel);
      chk("dec_en", int'(bus.dec_en), int'(m_phase == P_GRANT));
      chk("busy", int'(bus.busy), int'(m_phase != P_IDLE));
      chk("hold_cnt", int'(bus.hold_cnt), m_cnt);
    end
  end

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (m_phase == P_IDLE) return;
      @(negedge clk);
    end
    chk("timeout_idle", 0, 1);
  endtask

  task automatic wait_grants(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (grants.size() >= n) return;
      @(negedge clk);
    end
    chk("timeout_grants", grants.size(), n);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    bus.req = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_sel", int'(bus.sel), 0);
    chk("rst_dec_en", int'(bus.dec_en), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_hold", int'(bus.hold_cnt), 0);
    grants.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_sel", int'(bus.sel), 0);
    chk("first_en", int'(bus.dec_en), 1);

`ifndef ARB_FIXED_PRIORITY_EN
    wait_grants(9, 80);
    for (int i = 0; i < 9 && i < grants.size(); i++)
      chk("rr_order", grants[i], i % 8);

    bus.req = 8'h00;
    wait_idle(20);
    bus.req = 8'h04;
    @(negedge clk);
    chk("single_sel", int'(bus.sel), 2);
    chk("single_en", int'(bus.dec_en), 1);
    @(negedge clk);
    chk("single_hold", int'(bus.hold_cnt), 1);
    bus.req = 8'h00;
    @(negedge clk);
    chk("gap_en", int'(bus.dec_en), 0);
    chk("gap_busy", int'(bus.busy), 1);
    chk("gap_sel", int'(bus.sel), 2);
    @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);

    bus.req = 8'h20;
    @(negedge clk);
    bus.req = 8'h00;
    wait_idle(20);
    grants.delete();
    bus.req = 8'h21;
    wait_grants(2, 30);
    if (grants.size() >= 2) begin
      chk("fair_first", grants[0], 0);
      chk("fair_second", grants[1], 5);
    end

    bus.req = 8'h00;
    wait_idle(20);
    bus.req = 8'h08;
    @(negedge clk);
    bus.req = 8'h00;
    wait_idle(20);
    bus.req = 8'h18;
    @(negedge clk);
    chk("pre_rst_sel", int'(bus.sel), 4);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en", int'(bus.dec_en), 0);
    chk("async_busy", int'(bus.busy), 0);
    chk("async_hold", int'(bus.hold_cnt), 0);
    chk("async_sel", int'(bus.sel), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_sel", int'(bus.sel), 3);
    chk("restart_en", int'(bus.dec_en), 1);
`else
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk("fixed_en", int'(bus.dec_en), int'((c % 5) != 4));
      if ((c % 5) != 4) chk("fixed_sel", int'(bus.sel), 0);
    end
    grants.delete();
    bus.req = 8'hFE;
    wait_grants(3, 30);
    for (int i = 0; i < 3 && i < grants.size(); i++)
      chk("fixed_fe", grants[i], 1);
`endif

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0)
          bus.req = 8'($urandom);
        else
          bus.req = 8'($urandom) & 8'($urandom) & 8'($urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
